serial_pattern_matcher: RTL
===========================

// Module: serial_pattern_matcher
// PURPOSE
//  Parametrised serial string recogniser. Accepts a programmable PAT_W-bit pattern, shifts in a
//  serial bit stream MSB-first, and flags each occurrence in overlapping or non-overlapping mode.
//  Keeps saturating counts of received bits and matches, which feed the BCD/7-seg display path.
// PARAMETERS
//  PAT_W    4   pattern and shift-window width in bits (>=2)
//  CNT_W    7   width of the bit_cnt and match_cnt outputs
//  MAX_CNT  99  saturation value of both counters (must be <= 2**CNT_W-1); 99 fits two BCD digits
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous reset, active low
//  load        in   1      capture pat_in as the pattern; also clears window, fill, counts
//  pat_in      in   PAT_W  pattern value, sampled when load=1
//  clear       in   1      clear window, fill and counts; keep the pattern
//  bit_valid   in   1      qualifies bit_in for one cycle
//  bit_in      in   1      serial data bit
//  overlap     in   1      1=overlapping detection, 0=non-overlapping; sampled on each accepted bit
//  match       out  1      1-cycle pulse, registered, asserted the cycle after the completing bit
//  window      out  PAT_W  current shift window; the newest bit is at [0]
//  bit_cnt     out  CNT_W  accepted bits since the last load/clear, saturating
//  match_cnt   out  CNT_W  matches since the last load/clear, saturating
//  armed       out  1      1 when the window holds PAT_W valid bits (state ARMED)
// BEHAVIOUR
//  Reset: all outputs 0, pattern 0, fill 0, state IDLE.
//  FSM: IDLE (no pattern loaded) -> load -> FILL; FILL -> ARMED when fill reaches PAT_W;
//   ARMED -> FILL after a match when overlap=0; any state -> FILL on load; FILL/ARMED -> FILL on clear.
//  IDLE ignores bit_valid entirely: no shift, no counting.
//  Accepted bit (FILL/ARMED, bit_valid=1, no load, no clear):
//   - window <= {window[PAT_W-2:0], bit_in}
//   - fill <= min(fill+1, PAT_W)
//   - bit_cnt <= bit_cnt+1, saturating at MAX_CNT
//  Match condition: the new fill equals PAT_W and the new window equals the pattern.
//  On a match: match=1 on the next cycle; match_cnt increments, saturating at MAX_CNT.
//   - overlap=0: fill <= 0 and the state goes to FILL. The window still shifts, but the next
//     match needs PAT_W fresh bits.
//   - overlap=1: fill stays PAT_W. A match is possible on every following bit.
//  Priority within one cycle: load > clear > bit_valid. On load or clear the bit is dropped and
//   no match is raised.
//  A match pulse from the previous cycle is not cancelled by load or clear in the current cycle.
//  Saturated counters hold their value until load, clear or reset.
//  rst_n going low mid-stream clears everything asynchronously, including the loaded pattern.
// CONFIGURATION
//  PAT_MASK_EN defined:
//   - adds input pat_mask_in [PAT_W], captured together with the pattern on load
//     (reset value all ones)
//   - bit=1 compares that position; bit=0 makes it don't-care
//   - match condition becomes ((window ^ pattern) & mask) == 0
//  PAT_MASK_EN undefined:
//   - no pat_mask_in port; every pattern bit is compared
// STRUCTURE
//  Package serial_match_pkg:
//   - state enum {IDLE, FILL, ARMED}
//   - default PAT_W, CNT_W and MAX_CNT constants
//   - function sat_inc(value, max)
//  Sub-module sat_counter: CNT_W-bit, synchronous clear, enable, saturates at MAX_CNT.
//   Instantiated twice, for bit_cnt and match_cnt.
// TESTING
//  Run with PAT_W=4 and MAX_CNT=99 unless stated.
//  1. Overlap: load 4'b1011, overlap=1, stream 1,0,1,1,0,1,1
//     -> match pulses after bits 4 and 7; match_cnt=2, bit_cnt=7.
//  2. Non-overlap: same stream, overlap=0
//     -> one match after bit 4; match_cnt=1, armed=0 after bit 7 (fill=3).
//  3. Saturation: 120 accepted bits of 1 against pattern 4'b1111, overlap=1
//     -> bit_cnt=99, match_cnt=99, both held.
//  4. Priority: load 4'b0110 in the same cycle as bit_valid=1 -> bit dropped, bit_cnt=0,
//     window=0, state FILL. clear together with bit_valid -> counts 0, pattern kept.
//  5. Reset: bits in IDLE -> bit_cnt stays 0. Drop rst_n after 3 bits of a match
//     -> all outputs 0 immediately, no match pulse afterwards.
//  6. PAT_MASK_EN: pattern 4'b1001, mask 4'b1001 -> streams 1111 and 1001 both match;
//     stream 0111 does not.

Source files
------------

// File: rtl/serial_match_pkg.sv
// Shared types and helpers for the serial pattern matcher.
//   state_t     : matcher FSM states
//   DEF_*       : default parameter values for PAT_W, CNT_W, MAX_CNT
//   sat_inc()   : saturating increment used by the counters
package serial_match_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ARMED
  } state_t;

  localparam int unsigned DEF_PAT_W   = 4;
  localparam int unsigned DEF_CNT_W   = 7;
  localparam int unsigned DEF_MAX_CNT = 99;

  function automatic int unsigned sat_inc(input int unsigned value, input int unsigned max);
    return (value >= max) ? max : value + 1;
  endfunction

endpackage

// File: rtl/serial_pattern_matcher_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one step, holding at MAX_CNT
//   cnt        : current count
module sat_counter
  import serial_match_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned MAX_CNT = DEF_MAX_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= CNT_W'(sat_inc(32'(cnt), MAX_CNT));
    end
  end

endmodule

// File: rtl/serial_pattern_matcher.sv
// Serial string recogniser: shifts bit_in MSB-first into a PAT_W-bit window
// and pulses match when the window equals the loaded pattern.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load, pat_in : capture pattern; clears window, fill and counts
//   pat_mask_in  : per-bit compare enable, captured with the pattern
//                  (present only when PAT_MASK_EN is defined)
//   clear        : clear window, fill and counts, keep pattern
//   bit_valid, bit_in, overlap : serial input and detection mode
//   match        : registered one-cycle pulse after the completing bit
//   window       : shift window, newest bit at [0]
//   bit_cnt, match_cnt : saturating counts since last load/clear
//   armed        : window holds PAT_W valid bits
// Build option: define PAT_MASK_EN to enable the don't-care mask.
module serial_pattern_matcher
  import serial_match_pkg::*;
#(
  parameter int unsigned PAT_W   = DEF_PAT_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned MAX_CNT = DEF_MAX_CNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
`ifdef PAT_MASK_EN
  input  logic [PAT_W-1:0] pat_mask_in,
`endif
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             overlap,
  output logic             match,
  output logic [PAT_W-1:0] window,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_t            state;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-1:0]  mask;
  logic [FILL_W-1:0] fill;

  logic              accept;
  logic              hit;
  logic              cnt_clr;
  logic [PAT_W-1:0]  win_next;
  logic [FILL_W-1:0] fill_next;

`ifdef PAT_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (load) begin
      mask <= pat_mask_in;
    end
  end
`else
  assign mask = '1;
`endif

  // Match is judged on the post-shift window and fill, so the completing
  // bit itself is included in the comparison.
  always_comb begin
    accept    = (state != IDLE) && bit_valid && !load && !clear;
    win_next  = {window[PAT_W-2:0], bit_in};
    fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    hit       = accept && (fill_next == FILL_FULL) &&
                (((win_next ^ pattern) & mask) == '0);
    cnt_clr   = load || clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pattern <= '0;
      window  <= '0;
      fill    <= '0;
      match   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      match <= 1'b0;
      if (load) begin
        pattern <= pat_in;
        window  <= '0;
        fill    <= '0;
        state   <= FILL;
        armed   <= 1'b0;
      end else if (clear && state != IDLE) begin
        window <= '0;
        fill   <= '0;
        state  <= FILL;
        armed  <= 1'b0;
      end else if (accept) begin
        window <= win_next;
        match  <= hit;
        if (hit && !overlap) begin
          fill  <= '0;
          state <= FILL;
          armed <= 1'b0;
        end else begin
          fill <= fill_next;
          if (fill_next == FILL_FULL) begin
            state <= ARMED;
            armed <= 1'b1;
          end else begin
            state <= FILL;
            armed <= 1'b0;
          end
        end
      end
    end
  end

  sat_counter #(
    .CNT_W   (CNT_W),
    .MAX_CNT (MAX_CNT)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (accept),
    .cnt   (bit_cnt)
  );

  sat_counter #(
    .CNT_W   (CNT_W),
    .MAX_CNT (MAX_CNT)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (hit),
    .cnt   (match_cnt)
  );

endmodule
